pwm_fade_ctrl: RTL

APB-programmable duty-cycle sequencer that ramps a PWM peripheral's duty threshold from a start value to an end value in fixed steps, one step per programmed interval. It is an APB slave toward the CPU interconnect for configuration and an APB master toward the PWM peripheral's 16-bit register bank, where it writes only the duty register. It offloads LED/motor fades from software and raises a completion flag.

---
 rtl/pwm_fade_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: APB slave config, APB master that ramps a PWM duty register.
// Define PWM_FADE_IRQ_EN to add CTRL bit2 irq enable and drive done_irq.
module pwm_fade_ctrl (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic [9:0]  s_paddr,
  input  logic        s_psel,
  input  logic        s_penable,
  input  logic        s_pwrite,
  input  logic [15:0] s_pwdata,
  output logic [15:0] s_prdata,
  output logic        s_pready,
  output logic [9:0]  m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [15:0] m_pwdata,
  input  logic        m_pready,
  output logic        done_irq
);
  localparam logic [9:0] DUTY_ADDR = 10'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_DONE
  } state_t;

  state_t      state;
  logic [15:0] start_duty, end_duty, step, interval;
  logic [15:0] cur_duty, w_end, w_step, w_int, cnt;
  logic        w_up, busy, done, abort_pend;
  logic        wr, rd, start_req, abort_req;
  logic [16:0] sum, dif;
  logic [15:0] nxt, ctrl_rd;

  assign s_pready  = 1'b1;
  assign wr        = s_psel & s_penable & s_pwrite & s_pready;
  assign rd        = s_psel & s_penable & ~s_pwrite;
  assign abort_req = wr && s_paddr == 10'd0 && s_pwdata[1];
  assign start_req = wr && s_paddr == 10'd0 && s_pwdata[0]
                     && !s_pwdata[1];

`ifdef PWM_FADE_IRQ_EN
  logic irq_en;
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)
      irq_en <= 1'b0;
    else if (wr && s_paddr == 10'd0)
      irq_en <= s_pwdata[2];
  end
  assign done_irq = done & irq_en;
  assign ctrl_rd  = {13'd0, irq_en, 2'b00};
`else
  assign done_irq = 1'b0;
  assign ctrl_rd  = 16'd0;
`endif

  // 17-bit arithmetic so the clamp sees overflow/underflow
  assign sum = {1'b0, m_pwdata} + {1'b0, w_step};
  assign dif = {1'b0, m_pwdata} - {1'b0, w_step};

  always_comb begin
    nxt = w_end;
    if (w_step != 16'd0) begin
      if (w_up)
        nxt = (sum > {1'b0, w_end}) ? w_end : sum[15:0];
      else
        nxt = (dif[16] || dif[15:0] < w_end) ? w_end : dif[15:0];
    end
  end

  always_comb begin
    s_prdata = 16'd0;
    if (rd) begin
      case (s_paddr)
        10'd0:   s_prdata = ctrl_rd;
        10'd1:   s_prdata = start_duty;
        10'd2:   s_prdata = end_duty;
        10'd3:   s_prdata = step;
        10'd4:   s_prdata = interval;
        10'd5:   s_prdata = {14'd0, done, busy};
        10'd6:   s_prdata = cur_duty;
        default: s_prdata = 16'd0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      start_duty <= 16'd0;
      end_duty   <= 16'd0;
      step       <= 16'd0;
      interval   <= 16'd0;
    end else if (wr) begin
      case (s_paddr)
        10'd1:   start_duty <= s_pwdata;
        10'd2:   end_duty   <= s_pwdata;
        10'd3:   step       <= s_pwdata;
        10'd4:   interval   <= s_pwdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= S_IDLE;
      m_psel     <= 1'b0;
      m_penable  <= 1'b0;
      m_pwrite   <= 1'b0;
      m_paddr    <= 10'd0;
      m_pwdata   <= 16'd0;
      w_end      <= 16'd0;
      w_step     <= 16'd0;
      w_int      <= 16'd0;
      w_up       <= 1'b0;
      cnt        <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
      cur_duty   <= 16'd0;
    end else begin
      if (wr && s_paddr == 10'd5 && s_pwdata[1])
        done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_req) begin
            w_end      <= end_duty;
            w_step     <= step;
            w_int      <= interval;
            w_up       <= end_duty >= start_duty;
            m_pwdata   <= start_duty;
            done       <= 1'b0;
            busy       <= 1'b1;
            abort_pend <= 1'b0;
            m_psel     <= 1'b1;
            m_pwrite   <= 1'b1;
            m_paddr    <= DUTY_ADDR;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          m_penable <= 1'b1;
          state     <= S_ACCESS;
          if (abort_req)
            abort_pend <= 1'b1;
        end
        S_ACCESS: begin
          if (abort_req)
            abort_pend <= 1'b1;
          if (m_pready) begin
            cur_duty  <= m_pwdata;
            m_penable <= 1'b0;
            if (abort_pend || abort_req) begin
              m_psel     <= 1'b0;
              m_pwrite   <= 1'b0;
              m_paddr    <= 10'd0;
              busy       <= 1'b0;
              abort_pend <= 1'b0;
              state      <= S_IDLE;
            end else if (m_pwdata == w_end) begin
              m_psel   <= 1'b0;
              m_pwrite <= 1'b0;
              m_paddr  <= 10'd0;
              state    <= S_DONE;
            end else begin
              m_pwdata <= nxt;
              if (w_int == 16'd0) begin
                state <= S_SETUP;
              end else begin
                m_psel   <= 1'b0;
                m_pwrite <= 1'b0;
                m_paddr  <= 10'd0;
                cnt      <= w_int - 16'd1;
                state    <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (abort_req) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == 16'd0) begin
            m_psel   <= 1'b1;
            m_pwrite <= 1'b1;
            m_paddr  <= DUTY_ADDR;
            state    <= S_SETUP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (!abort_req)
            done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
